dhcp_vlg_rx: RTL



---
 rtl/dhcp_vlg_pkg.sv | 70 +++++++
 rtl/dhcp_vlg_if.sv | 12 +
 rtl/dhcp_vlg_rx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/dhcp_vlg_pkg.sv
// dhcp_vlg_pkg: DHCP constants, option codes and the header/option/presence types shared by the RX and TX paths.
package dhcp_vlg_pkg;
  localparam logic [31:0] DHCP_COOKIE = 32'h6382_5363;
  localparam int DHCP_HDR_LEN = 240;
  localparam int DHCP_STR_MAX = 32;
  localparam logic [7:0] DHCP_OPT_PAD = 8'd0;
  localparam logic [7:0] DHCP_OPT_SUBNET_MASK = 8'd1;
  localparam logic [7:0] DHCP_OPT_ROUTER = 8'd3;
  localparam logic [7:0] DHCP_OPT_DNS = 8'd6;
  localparam logic [7:0] DHCP_OPT_HOSTNAME = 8'd12;
  localparam logic [7:0] DHCP_OPT_DOMAIN_NAME = 8'd15;
  localparam logic [7:0] DHCP_OPT_LEASE_TIME = 8'd51;
  localparam logic [7:0] DHCP_OPT_MSG_TYPE = 8'd53;
  localparam logic [7:0] DHCP_OPT_SERVER_ID = 8'd54;
  localparam logic [7:0] DHCP_OPT_RENEWAL_TIME = 8'd58;
  localparam logic [7:0] DHCP_OPT_REBIND_TIME = 8'd59;
  localparam logic [7:0] DHCP_OPT_FQDN = 8'd81;
  localparam logic [7:0] DHCP_OPT_END = 8'd255;
  typedef struct packed {
    logic [7:0] dhcp_op;
    logic [7:0] dhcp_htype;
    logic [7:0] dhcp_hlen;
    logic [7:0] dhcp_hops;
    logic [31:0] dhcp_xid;
    logic [15:0] dhcp_secs;
    logic [15:0] dhcp_flags;
    logic [31:0] dhcp_ciaddr;
    logic [31:0] dhcp_yiaddr;
    logic [31:0] dhcp_siaddr;
    logic [31:0] dhcp_giaddr;
    logic [127:0] dhcp_chaddr;
    logic [511:0] dhcp_sname;
    logic [1023:0] dhcp_file;
    logic [31:0] dhcp_cookie;
  } dhcp_hdr_t;
  typedef struct packed {
    logic [7:0] dhcp_opt_message_type;
    logic [31:0] dhcp_opt_subnet_mask;
    logic [31:0] dhcp_opt_router;
    logic [31:0] dhcp_opt_dns;
    logic [31:0] dhcp_opt_lease_time;
    logic [31:0] dhcp_opt_server_id;
    logic [31:0] dhcp_opt_renewal_time;
    logic [31:0] dhcp_opt_rebind_time;
    logic [8*DHCP_STR_MAX-1:0] dhcp_opt_hostname;
    logic [8*DHCP_STR_MAX-1:0] dhcp_opt_domain_name;
    logic [8*DHCP_STR_MAX-1:0] dhcp_opt_fqdn;
  } dhcp_opt_hdr_t;
  typedef struct packed {
    logic dhcp_opt_message_type_pres;
    logic dhcp_opt_subnet_mask_pres;
    logic dhcp_opt_router_pres;
    logic dhcp_opt_dns_pres;
    logic dhcp_opt_lease_time_pres;
    logic dhcp_opt_server_id_pres;
    logic dhcp_opt_renewal_time_pres;
    logic dhcp_opt_rebind_time_pres;
    logic dhcp_opt_hostname_pres;
    logic dhcp_opt_domain_name_pres;
    logic dhcp_opt_fqdn_pres;
    logic dhcp_opt_end_pres;
  } dhcp_opt_pres_t;
  // Only the first four bytes of an option land in a 32-bit field.
  function automatic logic [31:0] dhcp_shift32(input logic [31:0] v, input logic [7:0] b, input logic [7:0] i);
    return (i < 8'd4) ? {v[23:0], b} : v;
  endfunction
  function automatic logic [8*DHCP_STR_MAX-1:0] dhcp_str_put(input logic [8*DHCP_STR_MAX-1:0] v, input logic [7:0] b, input logic [7:0] i);
    return v | ({b, {(8*DHCP_STR_MAX-8){1'b0}}} >> {i, 3'b000});
  endfunction
endpackage

// File: rtl/dhcp_vlg_if.sv
// dhcp_vlg_if: one validated DHCP message handed from the receive parser to the client core.
interface dhcp_vlg_if;
  import dhcp_vlg_pkg::*;
  dhcp_hdr_t hdr;
  dhcp_opt_hdr_t opt_hdr;
  dhcp_opt_pres_t opt_pres;
  logic [31:0] src_ip;
  logic [31:0] dst_ip;
  logic val;
  modport master(output hdr, opt_hdr, opt_pres, src_ip, dst_ip, val);
  modport slave(input hdr, opt_hdr, opt_pres, src_ip, dst_ip, val);
endinterface

// File: rtl/dhcp_vlg_rx.sv
// dhcp_vlg_rx: byte-serial DHCP message parser; define DHCP_RX_STRING_OPTS_EN to capture options 12, 15 and 81.
module dhcp_vlg_rx
  import dhcp_vlg_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR = 48'h0,
  parameter int HOSTNAME_LEN = 0,
  parameter int DOMAIN_NAME_LEN = 0,
  parameter int FQDN_LEN = 0
) (
  input logic clk,
  input logic rst,
  input logic [7:0] in_dat,
  input logic in_val,
  input logic in_sof,
  input logic in_eof,
  input logic in_err,
  input logic [31:0] in_src_ip,
  dhcp_vlg_if.master rx
);
  localparam logic [2:0] idle_s = 3'd0;
  localparam logic [2:0] hdr_s = 3'd1;
  localparam logic [2:0] code_s = 3'd2;
  localparam logic [2:0] len_s = 3'd3;
  localparam logic [2:0] dat_s = 3'd4;
  localparam logic [2:0] end_s = 3'd5;
  localparam logic [2:0] drop_s = 3'd6;
`ifdef DHCP_RX_STRING_OPTS_EN
  localparam bit STR_EN = 1'b1;
`else
  localparam bit STR_EN = 1'b0;
`endif
  localparam int HN = HOSTNAME_LEN < DHCP_STR_MAX ? HOSTNAME_LEN : DHCP_STR_MAX;
  localparam int DN = DOMAIN_NAME_LEN < DHCP_STR_MAX ? DOMAIN_NAME_LEN : DHCP_STR_MAX;
  localparam int FN = FQDN_LEN < DHCP_STR_MAX ? FQDN_LEN : DHCP_STR_MAX;
  logic [2:0] st, st_p, st_n;
  logic [15:0] cnt, cnt_n;
  logic [7:0] code, code_n, rem, rem_n, idx, idx_n;
  dhcp_hdr_t hdr, hdr_n;
  dhcp_opt_hdr_t opt, opt_n;
  dhcp_opt_pres_t pres, pres_n;
  logic last, commit;
  always_comb begin
    st_p = st;
    cnt_n = cnt;
    code_n = code;
    rem_n = rem;
    idx_n = idx;
    hdr_n = hdr;
    opt_n = opt;
    pres_n = pres;
    last = rem == 8'd1;
    if (in_val) begin
      cnt_n = (cnt == 16'hffff) ? cnt : cnt + 16'd1;
      if (in_sof) begin
        st_p = hdr_s;
        cnt_n = 16'd1;
        hdr_n = dhcp_hdr_t'({{($bits(dhcp_hdr_t)-8){1'b0}}, in_dat});
        opt_n = '0;
        pres_n = '0;
      end else begin
        case (st)
          hdr_s: begin
            hdr_n = dhcp_hdr_t'({hdr[$bits(dhcp_hdr_t)-9:0], in_dat});
            if (cnt == 16'(DHCP_HDR_LEN - 1))
              st_p = (hdr_n.dhcp_cookie != DHCP_COOKIE || hdr_n.dhcp_hlen != 8'd6 ||
                      hdr_n.dhcp_chaddr[127:80] != MAC_ADDR) ? drop_s : code_s;
          end
          code_s: begin
            st_p = (in_dat == DHCP_OPT_PAD) ? code_s : (in_dat == DHCP_OPT_END) ? end_s : len_s;
            code_n = in_dat;
            if (in_dat == DHCP_OPT_END) pres_n.dhcp_opt_end_pres = 1'b1;
          end
          len_s: begin
            st_p = (in_dat == 8'd0) ? code_s : dat_s;
            rem_n = in_dat;
            idx_n = 8'd0;
          end
          dat_s: begin
            st_p = last ? code_s : dat_s;
            rem_n = rem - 8'd1;
            idx_n = idx + 8'd1;
            case (code)
              DHCP_OPT_MSG_TYPE: begin
                if (idx == 8'd0) opt_n.dhcp_opt_message_type = in_dat;
                pres_n.dhcp_opt_message_type_pres = pres.dhcp_opt_message_type_pres | last;
              end
              DHCP_OPT_SUBNET_MASK: begin
                opt_n.dhcp_opt_subnet_mask = dhcp_shift32(opt.dhcp_opt_subnet_mask, in_dat, idx);
                pres_n.dhcp_opt_subnet_mask_pres = pres.dhcp_opt_subnet_mask_pres | last;
              end
              DHCP_OPT_ROUTER: begin
                opt_n.dhcp_opt_router = dhcp_shift32(opt.dhcp_opt_router, in_dat, idx);
                pres_n.dhcp_opt_router_pres = pres.dhcp_opt_router_pres | last;
              end
              DHCP_OPT_DNS: begin
                opt_n.dhcp_opt_dns = dhcp_shift32(opt.dhcp_opt_dns, in_dat, idx);
                pres_n.dhcp_opt_dns_pres = pres.dhcp_opt_dns_pres | last;
              end
              DHCP_OPT_LEASE_TIME: begin
                opt_n.dhcp_opt_lease_time = dhcp_shift32(opt.dhcp_opt_lease_time, in_dat, idx);
                pres_n.dhcp_opt_lease_time_pres = pres.dhcp_opt_lease_time_pres | last;
              end
              DHCP_OPT_SERVER_ID: begin
                opt_n.dhcp_opt_server_id = dhcp_shift32(opt.dhcp_opt_server_id, in_dat, idx);
                pres_n.dhcp_opt_server_id_pres = pres.dhcp_opt_server_id_pres | last;
              end
              DHCP_OPT_RENEWAL_TIME: begin
                opt_n.dhcp_opt_renewal_time = dhcp_shift32(opt.dhcp_opt_renewal_time, in_dat, idx);
                pres_n.dhcp_opt_renewal_time_pres = pres.dhcp_opt_renewal_time_pres | last;
              end
              DHCP_OPT_REBIND_TIME: begin
                opt_n.dhcp_opt_rebind_time = dhcp_shift32(opt.dhcp_opt_rebind_time, in_dat, idx);
                pres_n.dhcp_opt_rebind_time_pres = pres.dhcp_opt_rebind_time_pres | last;
              end
              // String fields start zeroed at sof, so bytes are ORed in left-aligned.
              DHCP_OPT_HOSTNAME: if (STR_EN) begin
                if (int'(idx) < HN) opt_n.dhcp_opt_hostname = dhcp_str_put(opt.dhcp_opt_hostname, in_dat, idx);
                pres_n.dhcp_opt_hostname_pres = pres.dhcp_opt_hostname_pres | last;
              end
              DHCP_OPT_DOMAIN_NAME: if (STR_EN) begin
                if (int'(idx) < DN) opt_n.dhcp_opt_domain_name = dhcp_str_put(opt.dhcp_opt_domain_name, in_dat, idx);
                pres_n.dhcp_opt_domain_name_pres = pres.dhcp_opt_domain_name_pres | last;
              end
              DHCP_OPT_FQDN: if (STR_EN) begin
                if (int'(idx) < FN) opt_n.dhcp_opt_fqdn = dhcp_str_put(opt.dhcp_opt_fqdn, in_dat, idx);
                pres_n.dhcp_opt_fqdn_pres = pres.dhcp_opt_fqdn_pres | last;
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
    commit = in_val && in_eof && !in_err && cnt_n >= 16'(DHCP_HDR_LEN) &&
             (st_p == code_s || st_p == end_s) && pres_n.dhcp_opt_message_type_pres;
    st_n = (in_val && in_eof) ? idle_s : st_p;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= idle_s;
      cnt <= '0;
      code <= '0;
      rem <= '0;
      idx <= '0;
      hdr <= '0;
      opt <= '0;
      pres <= '0;
      rx.hdr <= '0;
      rx.opt_hdr <= '0;
      rx.opt_pres <= '0;
      rx.src_ip <= '0;
      rx.val <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      code <= code_n;
      rem <= rem_n;
      idx <= idx_n;
      hdr <= hdr_n;
      opt <= opt_n;
      pres <= pres_n;
      rx.val <= commit;
      if (commit) begin
        rx.hdr <= hdr_n;
        rx.opt_hdr <= opt_n;
        rx.opt_pres <= pres_n;
        rx.src_ip <= in_src_ip;
      end
    end
  end
  assign rx.dst_ip = 32'hffff_ffff;
endmodule
